// File: rtl/band_scheduler.sv
// band_scheduler: frame-synchronous band table controller.
// On a tempo beat it builds a new set of band boundaries from random widths
// during vertical blanking, swaps it into the active table at a frame boundary,
// and tracks which band the current pixel belongs to.
module band_scheduler #(
  parameter int H_ACTIVE = 1280,
  parameter int BANDS    = 8,
  parameter int MIN_W    = 16,
  parameter int WBITS    = 8
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        frame_start,
  input  logic        beat,
  input  logic        display_en,
  input  logic [11:0] h_count,
  input  logic [12:0] rnd_in,
  output logic [2:0]  band_idx,
  output logic        band_valid,
  output logic [1:0]  mode,
  output logic        cfg_busy
);

  // k walks 0..BANDS-1; p and nbands must also represent BANDS itself
  localparam int KBITS = (BANDS > 1) ? $clog2(BANDS) : 1;
  localparam int PBITS = $clog2(BANDS + 1);

  localparam logic [12:0] H_LIM  = 13'(H_ACTIVE);
  localparam logic [12:0] MIN_WV = 13'(MIN_W);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t             state, state_next;
  logic [KBITS-1:0]   k, k_next;
  logic [12:0]        acc, acc_next;
  logic               clamped, clamped_next;
  logic [12:0]        shadow [BANDS];
  logic [12:0]        shadow_next [BANDS];
  logic [PBITS-1:0]   shadow_n, shadow_n_next;
  logic               beat_pending, beat_pending_next;
  logic               commit;
  logic [12:0]        width;
  logic [12:0]        sum;

  logic [12:0]        bound [BANDS];
  logic [PBITS-1:0]   nbands;

  logic [PBITS-1:0]   p, p_next, p_adv;
  logic [KBITS-1:0]   p_sel;
  logic [2:0]         idx_next;
  logic               valid_next;

  // Only the low WBITS of the LFSR word feed the band width
  logic unused_rnd_bits;
  assign unused_rnd_bits = ^rnd_in[12:WBITS];

  // Next-state logic: trigger a load on frame_start with a beat, build the shadow table, then commit
  always_comb begin
    state_next        = state;
    k_next            = k;
    acc_next          = acc;
    clamped_next      = clamped;
    shadow_next       = shadow;
    shadow_n_next     = shadow_n;
    beat_pending_next = beat_pending | beat;
    commit            = 1'b0;
    width             = MIN_WV + 13'(rnd_in[WBITS-1:0]);
    sum               = acc + width;

    case (state)
      IDLE: begin
        if (frame_start && (beat_pending || beat)) begin
          state_next        = LOAD;
          k_next            = '0;
          acc_next          = '0;
          clamped_next      = 1'b0;
          shadow_n_next     = PBITS'(BANDS);
          beat_pending_next = 1'b0;
        end
      end
      LOAD: begin
        if (!clamped) begin
          shadow_next[k] = (sum >= H_LIM) ? H_LIM : sum;
          acc_next       = sum;
          if (sum >= H_LIM) begin
            clamped_next  = 1'b1;
            shadow_n_next = PBITS'(k) + PBITS'(1);
          end
        end
        if (k == KBITS'(BANDS - 1)) begin
          state_next = COMMIT;
        end else begin
          k_next = k + KBITS'(1);
        end
      end
      COMMIT: begin
        commit     = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Configuration state register; cfg_busy is registered alongside the state
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      k            <= '0;
      acc          <= '0;
      clamped      <= 1'b0;
      shadow_n     <= '0;
      beat_pending <= 1'b0;
      cfg_busy     <= 1'b0;
      for (int i = 0; i < BANDS; i++) begin
        shadow[i] <= '0;
      end
    end else begin
      state        <= state_next;
      k            <= k_next;
      acc          <= acc_next;
      clamped      <= clamped_next;
      shadow_n     <= shadow_n_next;
      beat_pending <= beat_pending_next;
      cfg_busy     <= (state_next != IDLE);
      shadow       <= shadow_next;
    end
  end

  // Active table and pattern mode, swapped in only on the commit cycle
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      nbands <= PBITS'(BANDS);
      mode   <= 2'd0;
      for (int i = 0; i < BANDS; i++) begin
        bound[i] <= 13'((i + 1) * H_ACTIVE / BANDS);
      end
    end else if (commit) begin
      bound  <= shadow;
      nbands <= shadow_n;
      mode   <= mode + 2'd1;
    end
  end

  // Pixel tracking: one comparator against the current bound, pointer steps by at most one
  always_comb begin
    p_sel      = p[KBITS-1:0];
    p_next     = p;
    p_adv      = p;
    valid_next = 1'b0;
    idx_next   = 3'd0;
    if (!display_en) begin
      p_next = '0;
    end else if (p < nbands) begin
      p_adv  = ({1'b0, h_count} >= bound[p_sel]) ? p + PBITS'(1) : p;
      p_next = p_adv;
      if (p_adv < nbands) begin
        valid_next = 1'b1;
        idx_next   = 3'(p_adv);
      end
    end
  end

  // Pixel pointer and band outputs, one cycle behind h_count
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      p          <= '0;
      band_idx   <= 3'd0;
      band_valid <= 1'b0;
    end else begin
      p          <= p_next;
      band_idx   <= idx_next;
      band_valid <= valid_next;
    end
  end

endmodule

// File: tb/tb_band_scheduler.sv
// tb_band_scheduler: directed test of band_scheduler with hand-computed band tables.
module tb_band_scheduler;

  logic        clk_in;
  logic        reset;
  logic        frame_start;
  logic        beat;
  logic        display_en;
  logic [11:0] h_count;
  logic [12:0] rnd_in;
  logic [2:0]  band_idx;
  logic        band_valid;
  logic [1:0]  mode;
  logic        cfg_busy;

  int checks;
  int errors;
  int exp_bound [8];
  int exp_n;
  int busy_cnt;

  band_scheduler #(
    .H_ACTIVE(1280),
    .BANDS   (8),
    .MIN_W   (16),
    .WBITS   (8)
  ) dut (
    .clk_in     (clk_in),
    .reset      (reset),
    .frame_start(frame_start),
    .beat       (beat),
    .display_en (display_en),
    .h_count    (h_count),
    .rnd_in     (rnd_in),
    .band_idx   (band_idx),
    .band_valid (band_valid),
    .mode       (mode),
    .cfg_busy   (cfg_busy)
  );

  // 10 ns pixel clock
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Expected band for pixel h: first boundary strictly above h, invalid past the table
  task automatic expBand(input int h, output int idx, output int valid);
    idx   = 0;
    valid = 0;
    for (int j = 0; j < exp_n; j++) begin
      if (h < exp_bound[j]) begin
        idx   = j;
        valid = 1;
        break;
      end
    end
  endtask

  // One display line from h_count 0 to last_h, then blanking
  task automatic lineSweep(input string tag, input int last_h);
    int ei, ev;
    display_en = 1'b1;
    for (int h = 0; h <= last_h; h++) begin
      h_count = 12'(h);
      tick();
      expBand(h, ei, ev);
      checkOutput({tag, "_idx"}, int'(band_idx), ei);
      checkOutput({tag, "_valid"}, int'(band_valid), ev);
    end
    display_en = 1'b0;
    h_count    = 12'd0;
    tick();
    checkOutput({tag, "_blank_valid"}, int'(band_valid), 0);
    checkOutput({tag, "_blank_idx"}, int'(band_idx), 0);
    tick();
  endtask

  // Optional beat, frame_start (optionally with a coincident beat), then watch cfg_busy
  task automatic applyStimulus(input logic [12:0] rnd, input bit pre_beat, input bit co_beat,
                               input bit mid_beat, output int busy);
    rnd_in = rnd;
    if (pre_beat) begin
      beat = 1'b1;
      tick();
      beat = 1'b0;
      tick();
    end
    frame_start = 1'b1;
    beat        = co_beat;
    tick();
    frame_start = 1'b0;
    beat        = 1'b0;
    busy        = 0;
    for (int i = 0; i < 40; i++) begin
      if (cfg_busy) busy++;
      beat = (mid_beat && i == 2);
      tick();
      beat = 1'b0;
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    reset       = 1'b0;
    frame_start = 1'b0;
    beat        = 1'b0;
    display_en  = 1'b0;
    h_count     = 12'd0;
    rnd_in      = 13'd0;

    // Reset state
    #3;
    checkOutput("rst_busy", int'(cfg_busy), 0);
    checkOutput("rst_valid", int'(band_valid), 0);
    checkOutput("rst_idx", int'(band_idx), 0);
    checkOutput("rst_mode", int'(mode), 0);
    tick();
    tick();
    reset = 1'b1;
    tick();

    // 1: default 160-pixel table
    $display("[TB] test 1 default table");
    exp_bound = '{160, 320, 480, 640, 800, 960, 1120, 1280};
    exp_n     = 8;
    lineSweep("t1", 1279);
    checkOutput("t1_mode", int'(mode), 0);

    // 2: clamped load, width 271 each
    $display("[TB] test 2 clamped load");
    applyStimulus(13'h0FF, 1'b1, 1'b0, 1'b0, busy_cnt);
    checkOutput("t2_busy_cycles", busy_cnt, 9);
    checkOutput("t2_mode", int'(mode), 1);
    exp_bound = '{271, 542, 813, 1084, 1280, 0, 0, 0};
    exp_n     = 5;
    lineSweep("t2", 1279);

    // 3: short table, width 16 each
    $display("[TB] test 3 short table");
    applyStimulus(13'h000, 1'b1, 1'b0, 1'b0, busy_cnt);
    checkOutput("t3_busy_cycles", busy_cnt, 9);
    checkOutput("t3_mode", int'(mode), 2);
    exp_bound = '{16, 32, 48, 64, 80, 96, 112, 128};
    exp_n     = 8;
    lineSweep("t3_line1", 1279);
    lineSweep("t3_line2", 200);

    // 4: frame_start with no beat leaves everything alone
    $display("[TB] test 4 no beat");
    applyStimulus(13'h0FF, 1'b0, 1'b0, 1'b0, busy_cnt);
    checkOutput("t4_busy_cycles", busy_cnt, 0);
    checkOutput("t4_mode", int'(mode), 2);
    lineSweep("t4", 300);

    // 5: beat during LOAD carries over; then coincident beat also loads
    $display("[TB] test 5 beat during load");
    applyStimulus(13'h040, 1'b1, 1'b0, 1'b1, busy_cnt);
    checkOutput("t5a_busy_cycles", busy_cnt, 9);
    checkOutput("t5a_mode", int'(mode), 3);
    exp_bound = '{80, 160, 240, 320, 400, 480, 560, 640};
    exp_n     = 8;
    lineSweep("t5a", 700);
    applyStimulus(13'h070, 1'b0, 1'b0, 1'b0, busy_cnt);
    checkOutput("t5b_busy_cycles", busy_cnt, 9);
    checkOutput("t5b_mode", int'(mode), 0);
    exp_bound = '{128, 256, 384, 512, 640, 768, 896, 1024};
    lineSweep("t5b", 1100);
    applyStimulus(13'h030, 1'b0, 1'b1, 1'b0, busy_cnt);
    checkOutput("t5c_busy_cycles", busy_cnt, 9);
    checkOutput("t5c_mode", int'(mode), 1);
    exp_bound = '{64, 128, 192, 256, 320, 384, 448, 512};
    lineSweep("t5c", 600);

    // 6: asynchronous reset in the middle of LOAD
    $display("[TB] test 6 reset mid-load");
    display_en  = 1'b1;
    h_count     = 12'd0;
    rnd_in      = 13'h0FF;
    beat        = 1'b1;
    tick();
    beat        = 1'b0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    tick();
    checkOutput("t6_pre_busy", int'(cfg_busy), 1);
    checkOutput("t6_pre_valid", int'(band_valid), 1);
    checkOutput("t6_pre_mode", int'(mode), 1);
    reset = 1'b0;
    #1;
    checkOutput("t6_async_busy", int'(cfg_busy), 0);
    checkOutput("t6_async_valid", int'(band_valid), 0);
    checkOutput("t6_async_mode", int'(mode), 0);
    display_en = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    exp_bound = '{160, 320, 480, 640, 800, 960, 1120, 1280};
    exp_n     = 8;
    lineSweep("t6", 1279);
    checkOutput("t6_busy_after", int'(cfg_busy), 0);
    checkOutput("t6_mode_after", int'(mode), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
